// File: rtl/matmul_result_sink.sv
// Accumulates SIZE_COLUMN signed operand products per row and queues each finished
// dot product, tagged with its row index, in a small FIFO for a downstream consumer.
module matmul_result_sink #(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 20,
    parameter int SIZE_COLUMN = 4,
    parameter int SIZE_ROW    = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              CLOCK_25,
    input  logic              rst,
    input  logic              i_clr,
    input  logic [4:0]        i_column_adr,
    input  logic [4:0]        i_row_adr,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [ACC_W-1:0]  o_res_data,
    output logic [4:0]        o_res_row,
    output logic [1:0]        o_state,
    output logic              o_overflow,
    output logic              o_seq_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = ACC_W + 5;
    localparam logic [4:0] LAST_COL = 5'(SIZE_COLUMN - 1);
    localparam logic [4:0] LAST_ROW = 5'(SIZE_ROW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ACC_W-1:0] acc;
    logic [4:0]       exp_col;
    logic             seq_err_q;
    logic             overflow_q;

    logic take_term;
    logic push_req;
    logic seq_fault;
    logic clear_acc;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]           acc_base;
    logic [ACC_W-1:0]           acc_sum;
    logic                       is_last_col;
    logic                       is_last_row;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;
    logic          dropped;
    logic [EW-1:0] head;

    // Full-width signed product, sign-extended; the sum wraps modulo 2^ACC_W.
    assign prod        = $signed(i_a) * $signed(i_b);
    assign prod_ext    = ACC_W'(prod);
    assign acc_base    = (state == ST_IDLE) ? '0 : acc;
    assign acc_sum     = acc_base + prod_ext;
    assign is_last_col = (i_column_adr == LAST_COL);
    assign is_last_row = (i_row_adr == LAST_ROW);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state and datapath controls ----------------
    always_comb begin
        state_next = state;
        take_term  = 1'b0;
        push_req   = 1'b0;
        seq_fault  = 1'b0;
        clear_acc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!i_clr && i_column_adr == 5'd0) begin
                    take_term  = 1'b1;
                    state_next = ST_ACC;
                    if (is_last_col) begin
                        push_req = 1'b1;
                        if (is_last_row) state_next = ST_DONE;
                    end
                end
            end
            ST_ACC: begin
                if (i_clr) begin
                    clear_acc = 1'b1;
                end else if (i_column_adr == exp_col) begin
                    take_term = 1'b1;
                    if (is_last_col) begin
                        push_req = 1'b1;
                        if (is_last_row) state_next = ST_DONE;
                    end
                end else begin
                    seq_fault  = 1'b1;
                    clear_acc  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (i_clr) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_state = state;
    end

    // ---------------- Accumulator and column tracking ----------------
    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            acc       <= '0;
            exp_col   <= '0;
            seq_err_q <= 1'b0;
        end else begin
            if (seq_fault) seq_err_q <= 1'b1;
            if (clear_acc) begin
                acc     <= '0;
                exp_col <= '0;
            end else if (take_term) begin
                if (push_req) begin
                    acc     <= '0;
                    exp_col <= '0;
                end else begin
                    acc     <= acc_sum;
                    exp_col <= i_column_adr + 5'd1;
                end
            end
        end
    end

    // ---------------- Result FIFO ----------------
    // Handshake: an entry transfers on any rising edge where o_res_valid && i_res_ready;
    // o_res_valid/data/row depend only on stored state, never on i_res_ready.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && i_res_ready;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign dropped    = push_req && fifo_full && !pop;
    assign head       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLOCK_25) begin
        if (!rst && push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {i_row_adr, acc_sum};
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
            if (dropped) overflow_q <= 1'b1;
        end
    end

    // Head fields read as zero whenever the FIFO is empty, including right after reset.
    always_comb begin
        o_res_valid = !fifo_empty;
        o_res_data  = fifo_empty ? '0 : head[ACC_W-1:0];
        o_res_row   = fifo_empty ? '0 : head[EW-1:ACC_W];
        o_overflow  = overflow_q;
        o_seq_err   = seq_err_q;
    end

endmodule

// File: tb/tb_matmul_result_sink.sv
// Directed and randomized bench for matmul_result_sink with a queue-based scoreboard
// that models FIFO occupancy, overflow drops and head ordering.
module tb_matmul_result_sink;

    localparam int DATA_W      = 8;
    localparam int ACC_W       = 20;
    localparam int SIZE_COLUMN = 4;
    localparam int SIZE_ROW    = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int W           = ACC_W + 5;

    logic              CLOCK_25     = 1'b0;
    logic              rst          = 1'b1;
    logic              i_clr        = 1'b1;
    logic [4:0]        i_column_adr = '0;
    logic [4:0]        i_row_adr    = '0;
    logic [DATA_W-1:0] i_a          = '0;
    logic [DATA_W-1:0] i_b          = '0;
    logic              i_res_ready  = 1'b0;
    logic              o_res_valid;
    logic [ACC_W-1:0]  o_res_data;
    logic [4:0]        o_res_row;
    logic [1:0]        o_state;
    logic              o_overflow;
    logic              o_seq_err;

    int          checks     = 0;
    int          errors     = 0;
    bit          rand_ready = 1'b0;
    bit          model_ovf  = 1'b0;
    logic [W-1:0] exp_q[$];

    matmul_result_sink #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .SIZE_COLUMN(SIZE_COLUMN),
        .SIZE_ROW(SIZE_ROW), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLOCK_25(CLOCK_25), .rst(rst), .i_clr(i_clr),
        .i_column_adr(i_column_adr), .i_row_adr(i_row_adr),
        .i_a(i_a), .i_b(i_b),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_data(o_res_data), .o_res_row(o_res_row),
        .o_state(o_state), .o_overflow(o_overflow), .o_seq_err(o_seq_err)
    );

    // ---------------- clock / reset ----------------
    always #5 CLOCK_25 = ~CLOCK_25;

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        i_clr = 1'b1;
        @(posedge CLOCK_25); #1;
        rst = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic term(input int row, input int col, input int a, input int b);
        i_clr        = 1'b0;
        i_row_adr    = 5'(row);
        i_column_adr = 5'(col);
        i_a          = DATA_W'(a);
        i_b          = DATA_W'(b);
        if (rand_ready) i_res_ready = 1'($urandom_range(0, 1));
        @(posedge CLOCK_25); #1;
    endtask

    task automatic idle(input int n);
        i_clr = 1'b1;
        repeat (n) begin
            if (rand_ready) i_res_ready = 1'($urandom_range(0, 1));
            @(posedge CLOCK_25); #1;
        end
    endtask

    // One full dot product; the model result is queued after the final edge, or
    // recorded as a drop when the modelled FIFO is already full.
    task automatic dot(input int row, input int av[SIZE_COLUMN], input int bv[SIZE_COLUMN],
                       input bit rdy_last);
        int               sum;
        logic [ACC_W-1:0] ev;
        sum = 0;
        for (int c = 0; c < SIZE_COLUMN; c++) begin
            if (rdy_last && c == SIZE_COLUMN - 1) i_res_ready = 1'b1;
            sum += av[c] * bv[c];
            term(row, c, av[c], bv[c]);
        end
        ev = sum[ACC_W-1:0];
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({5'(row), ev});
        else model_ovf = 1'b1;
        if (rdy_last) i_res_ready = 1'b0;
        i_clr = 1'b1;
    endtask

    task automatic pass(input int a0[SIZE_COLUMN], input int b0[SIZE_COLUMN],
                        input int a1[SIZE_COLUMN], input int b1[SIZE_COLUMN]);
        dot(0, a0, b0, 1'b0);
        dot(1, a1, b1, 1'b0);
        chk("state_done", 32'(o_state), 32'd2);
        idle(1);
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic rand_pass();
        int ra[SIZE_COLUMN], rb[SIZE_COLUMN], rc[SIZE_COLUMN], rd[SIZE_COLUMN];
        for (int i = 0; i < SIZE_COLUMN; i++) begin
            ra[i] = rnd8(); rb[i] = rnd8(); rc[i] = rnd8(); rd[i] = rnd8();
        end
        pass(ra, rb, rc, rd);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        i_res_ready = 1'b1;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge CLOCK_25); #1;
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge CLOCK_25) begin
        logic [W-1:0] e;
        if (!rst) begin
            chk("res_valid", 32'(o_res_valid), 32'(exp_q.size() != 0));
            if (o_res_valid && i_res_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res_data", 32'(o_res_data), 32'(e[ACC_W-1:0]));
                chk("res_row", 32'(o_res_row), 32'(e[W-1:ACC_W]));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(posedge CLOCK_25);
        #1;
        do_reset();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_valid", 32'(o_res_valid), 32'd0);
        chk("rst_data", 32'(o_res_data), 32'd0);
        chk("rst_row", 32'(o_res_row), 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        chk("rst_seq_err", 32'(o_seq_err), 32'd0);

        // Basic two-row pass with a free-running consumer
        i_res_ready = 1'b1;
        dot(0, '{1, 2, 3, 4}, '{5, 6, 7, 8}, 1'b0);
        chk("latency_valid", 32'(o_res_valid), 32'd1);
        chk("latency_data", 32'(o_res_data), 32'd70);
        chk("latency_row", 32'(o_res_row), 32'd0);
        dot(1, '{1, 2, 3, 4}, '{5, 6, 7, 8}, 1'b0);
        chk("basic_state_done", 32'(o_state), 32'd2);
        chk("basic_row1", 32'(o_res_row), 32'd1);
        idle(2);
        chk("basic_back_idle", 32'(o_state), 32'd0);

        // Signed extremes
        dot(0, '{-128, -128, -128, -128}, '{127, 127, 127, 127}, 1'b0);
        chk("signed_data", 32'(o_res_data), 32'h000F0200);
        dot(1, '{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 1'b0);
        chk("signed_state", 32'(o_state), 32'd2);
        idle(2);

        // Backpressure: six results into a four-deep FIFO
        i_res_ready = 1'b0;
        for (int p = 0; p < 3; p++) rand_pass();
        chk("bp_overflow", 32'(o_overflow), 32'd1);
        chk("bp_model_ovf", 32'(model_ovf), 32'd1);
        drain(20);
        idle(1);

        // Full FIFO with a pop on the push cycle
        do_reset();
        i_res_ready = 1'b0;
        for (int p = 0; p < 2; p++) rand_pass();
        dot(0, '{9, -3, 17, 100}, '{-2, 44, 5, -60}, 1'b1);
        chk("full_pop_overflow", 32'(o_overflow), 32'd0);
        idle(1);
        drain(20);
        idle(1);

        // Sequence error then a clean pass
        term(0, 0, 3, 3);
        term(0, 1, 3, 3);
        term(0, 3, 3, 3);
        chk("seq_err_flag", 32'(o_seq_err), 32'd1);
        chk("seq_err_state", 32'(o_state), 32'd0);
        chk("seq_err_nopush", 32'(o_res_valid), 32'd0);
        idle(1);
        i_res_ready = 1'b1;
        pass('{10, -20, 30, -40}, '{1, 1, 1, 1}, '{7, 7, 7, 7}, '{-7, 8, -9, 10});
        idle(1);

        // Reset in the middle of a row
        term(0, 0, 50, 50);
        term(0, 1, 50, 50);
        term(0, 2, 50, 50);
        do_reset();
        chk("midrst_state", 32'(o_state), 32'd0);
        chk("midrst_valid", 32'(o_res_valid), 32'd0);
        chk("midrst_seq_err", 32'(o_seq_err), 32'd0);
        i_res_ready = 1'b1;
        pass('{2, 2, 2, 2}, '{3, 3, 3, 3}, '{-1, -1, -1, -1}, '{127, 127, 127, 127});
        idle(1);

        // Random operands with a random consumer
        rand_ready = 1'b1;
        for (int p = 0; p < 4; p++) rand_pass();
        rand_ready = 1'b0;
        drain(40);
        chk("rand_overflow", 32'(o_overflow), 32'(model_ovf));
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
